// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch stage: credit-limited fetch into an in-order FIFO,
// with redirect flush that drops in-flight responses by count.
module instr_prefetch_buffer #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_fault
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       data;
        logic              err;
    } ent_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     twptr_q, trptr_q;
    ent_t              fifo_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];

    logic [SW-1:0] used;
    logic          gnt;
    logic          rsp_live;
    logic          push;
    logic          pop;

    // Credits count buffered, in-flight and to-be-dropped words alike.
    assign used      = SW'(out_q) + SW'(cnt_q) + SW'(drop_q);
    assign imem_req  = rst_n && !redirect_valid && (used < DEPTH_S);
    assign imem_addr = fetch_pc_q;
    assign gnt       = imem_req && imem_gnt;
    assign rsp_live  = imem_rvalid && (drop_q == '0);
    assign push      = rsp_live && !redirect_valid;
    assign pop       = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (cnt_q != '0);
    assign instr_data  = fifo_q[rptr_q].data;
    assign instr_pc    = fifo_q[rptr_q].pc;
    assign instr_fault = fifo_q[rptr_q].err;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            out_d      = '0;
            drop_d     = drop_q + out_q - CW'(imem_rvalid);
            cnt_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (gnt) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            out_d  = out_q + CW'(gnt) - CW'(rsp_live);
            drop_d = drop_q - CW'(imem_rvalid && (drop_q != '0));
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
            wptr_d = wptr_q + PW'(push);
            rptr_d = rptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            twptr_q    <= '0;
            trptr_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            // Tag queue tracks every grant, dropped ones included.
            if (gnt) begin
                tag_q[twptr_q] <= imem_addr;
                twptr_q        <= twptr_q + PW'(1);
            end
            if (imem_rvalid) begin
                trptr_q <= trptr_q + PW'(1);
            end
            if (push) begin
                fifo_q[wptr_q] <= '{pc: tag_q[trptr_q],
                                    data: imem_rdata,
                                    err: imem_err};
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: memory model, grant-driven scoreboard
// and directed checks on redirect, back-pressure, faults, wrap and reset.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          imem_err;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_fault;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    int          gcnt  = 0;
    int          fcnt  = 0;
    logic [31:0] err_addr = 32'h0000_1000;
    pend_t       pend[$];
    exp_t        exp[$];
    exp_t        e;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(
        .DEPTH(DEPTH),
        .ADDR_W(AW),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .imem_err(imem_err),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_fault(instr_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic mem_drive();
        pend_t p;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h13 + p.addr;
            imem_err    = (p.addr == err_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hdead_beef;
            imem_err    = 1'b1;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset(input logic rdy);
        nxt();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        pend.delete();
        exp.delete();
        imem_rvalid    = 1'b0;
        nxt();
        nxt();
        instr_ready = rdy;
        rst_n       = 1'b1;
        gcnt        = 0;
        fcnt        = 0;
    endtask

    task automatic drain();
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (exp.size() == 0 && pend.size() == 0 && !instr_valid) break;
            nxt();
        end
        #1;
        chk("drain_left", 32'(exp.size()), 32'd0);
    endtask

    // Scoreboard: each grant queues its expected word; redirect flushes all.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected actual pc=%h required none",
                             instr_pc);
                end else begin
                    e = exp.pop_front();
                    chk("sb_pc", instr_pc, e.pc);
                    chk("sb_data", instr_data, e.data);
                    chk("sb_fault", 32'(instr_fault), 32'(e.fault));
                    if (instr_fault) fcnt++;
                end
            end
            if (redirect_valid) exp.delete();
            if (imem_req && imem_gnt) begin
                pend.push_back('{addr: imem_addr, due: cyc + lat});
                exp.push_back('{pc: imem_addr, data: 32'h13 + imem_addr,
                                fault: (imem_addr == err_addr)});
                gcnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        instr_ready    = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'hdead_beef;
        imem_err       = 1'b0;
        #1 rst_n = 1'b0;
        imem_gnt = 1'b1;
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", instr_data, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(instr_fault), 32'd0);

        // Streaming, one word per cycle
        lat         = 1;
        instr_ready = 1'b1;
        nxt();
        rst_n = 1'b1;
        gcnt  = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t1_addr", imem_addr, 32'(k));
            if (k >= 2) begin
                chk("t1_valid", 32'(instr_valid), 32'd1);
                chk("t1_pc", instr_pc, 32'(k - 2));
                chk("t1_data", instr_data, 32'h13 + 32'(k - 2));
            end
            nxt();
        end
        drain();

        // Back-pressure fills exactly DEPTH credits
        do_reset(1'b0);
        lat      = 1;
        imem_gnt = 1'b1;
        repeat (8) nxt();
        #1;
        chk("t2_grants", 32'(gcnt), 32'd4);
        chk("t2_req", 32'(imem_req), 32'd0);
        chk("t2_valid", 32'(instr_valid), 32'd1);
        chk("t2_pc", instr_pc, 32'd0);
        instr_ready = 1'b1;
        nxt();
        #1;
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'd4);
        drain();

        // Redirect with two slow responses in flight
        do_reset(1'b1);
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        #1;
        chk("t3_redir_req", 32'(imem_req), 32'd0);
        nxt();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        #1;
        chk("t3_addr5", imem_addr, 32'd5);
        nxt();
        nxt();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        nxt();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        #1;
        chk("t3_addr40", imem_addr, 32'h40);
        for (int n = 0; n < 10 && !instr_valid; n++) begin
            nxt();
            #1;
        end
        chk("t3_valid", 32'(instr_valid), 32'd1);
        chk("t3_pc", instr_pc, 32'h40);
        chk("t3_data", instr_data, 32'h53);
        drain();

        // Redirect coincides with a live response and a pop, count=2
        do_reset(1'b0);
        lat      = 2;
        imem_gnt = 1'b1;
        repeat (4) nxt();
        imem_gnt       = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        #1;
        chk("t4_pre_valid", 32'(instr_valid), 32'd1);
        chk("t4_pre_pc", instr_pc, 32'd0);
        nxt();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        #1;
        chk("t4_flushed", 32'(instr_valid), 32'd0);
        chk("t4_addr", imem_addr, 32'h20);
        chk("t4_req", 32'(imem_req), 32'd1);
        nxt();
        #1;
        chk("t4_drop", 32'(instr_valid), 32'd0);
        nxt();
        nxt();
        #1;
        chk("t4_valid", 32'(instr_valid), 32'd1);
        chk("t4_pc", instr_pc, 32'h20);
        drain();

        // Bus error on pc 3 only
        do_reset(1'b1);
        lat      = 1;
        err_addr = 32'd3;
        imem_gnt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k >= 2) begin
                chk("t5_pc", instr_pc, 32'(k - 2));
                chk("t5_fault", 32'(instr_fault), 32'((k - 2) == 3));
            end
            nxt();
        end
        drain();
        chk("t5_fault_cnt", 32'(fcnt), 32'd1);
        err_addr = 32'h0000_1000;

        // Address wrap, then async reset mid-stream
        do_reset(1'b1);
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_ffff;
        nxt();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b1;
        #1;
        chk("t6_addr_max", imem_addr, 32'hffff_ffff);
        nxt();
        #1;
        chk("t6_addr_wrap", imem_addr, 32'd0);
        nxt();
        #1;
        chk("t6_pc_max", instr_pc, 32'hffff_ffff);
        chk("t6_data_max", instr_data, 32'h12);
        nxt();
        nxt();
        rst_n = 1'b0;
        pend.delete();
        exp.delete();
        imem_rvalid = 1'b0;
        #1;
        chk("t6_rst_req", 32'(imem_req), 32'd0);
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_data", instr_data, 32'd0);
        chk("t6_rst_pc", instr_pc, 32'd0);
        chk("t6_rst_fault", 32'(instr_fault), 32'd0);
        nxt();
        nxt();
        rst_n = 1'b1;
        #1;
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'd0);
        nxt();
        nxt();
        #1;
        chk("t6_restart_pc", instr_pc, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
